mem_arbiter: RTL and testbench

//  Sole owner of the 8-bit RAM/IO bus (mem_din/mem_dout/mem_a/mem_wr) inside cpu.

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial owner of the external RAM/IO bus, shared by instruction fetch and load/store.
// Multi-byte requests are split into byte accesses; read data is assembled little-endian.
module mem_arbiter #(
    parameter int         INST_BYTES = 4,
    parameter logic [1:0] IO_HI      = 2'b11
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_in,
    input  logic                    if_req,
    input  logic [31:0]             if_addr,
    output logic                    if_done,
    output logic [8*INST_BYTES-1:0] if_data,
    input  logic                    ls_req,
    input  logic                    ls_wr,
    input  logic [1:0]              ls_len,
    input  logic [31:0]             ls_addr,
    input  logic [31:0]             ls_wdata,
    output logic                    ls_done,
    output logic [31:0]             ls_rdata,
    output logic                    busy,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);
    localparam int DW = 8 * INST_BYTES;

    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

    state_t        state, state_nx;
    logic [31:0]   base, wdata;
    logic [4:0]    len, cnt;
    logic          pend, own_if;
    logic [DW-1:0] dbuf;

    logic [4:0]  idx, ls_n;
    logic [31:0] addr;
    logic        io_stall, rd_last, wr_last, wr_go;

    // cnt counts captured (read) or issued (write) bytes; pend marks a read address
    // driven last cycle with rdy_in=1, whose byte is on mem_din now.
    always_comb begin
        idx      = cnt + 5'(pend);
        addr     = base + 32'(idx);
        io_stall = (addr[17:16] == IO_HI) && io_buffer_full;
        rd_last  = pend && (cnt == len - 5'd1);
        wr_last  = (cnt == len - 5'd1);
        wr_go    = rdy_in && !io_stall;
        case (ls_len)
            2'b00:   ls_n = 5'd1;
            2'b01:   ls_n = 5'd2;
            default: ls_n = 5'd4;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (rdy_in) begin
                if (ls_req)                  state_nx = ls_wr ? LS_WR : LS_RD;
                else if (if_req && !clear_in) state_nx = IF_RD;
            end
            IF_RD: if (rdy_in) begin
                if (clear_in)     state_nx = IDLE;
                else if (rd_last) state_nx = DONE;
            end
            LS_RD: if (rdy_in && rd_last) state_nx = DONE;
            LS_WR: if (wr_go && wr_last)  state_nx = DONE;
            DONE:  if (rdy_in)            state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        if_done  = 1'b0;
        ls_done  = 1'b0;
        case (state)
            IF_RD, LS_RD: if (idx < len) mem_a = addr;
            LS_WR: begin
                mem_a    = addr;
                mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
                mem_wr   = wr_go;
            end
            DONE: begin
                if_done = rdy_in && own_if && !clear_in;
                ls_done = rdy_in && !own_if;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            base   <= 32'd0;
            wdata  <= 32'd0;
            len    <= 5'd0;
            cnt    <= 5'd0;
            pend   <= 1'b0;
            own_if <= 1'b0;
            dbuf   <= '0;
        end else if (rdy_in) begin
            case (state)
                IDLE: if (state_nx != IDLE) begin
                    base   <= ls_req ? ls_addr : if_addr;
                    len    <= ls_req ? ls_n : 5'(INST_BYTES);
                    wdata  <= ls_wdata;
                    own_if <= !ls_req;
                    cnt    <= 5'd0;
                    pend   <= 1'b0;
                    dbuf   <= '0;
                end
                IF_RD, LS_RD: begin
                    if (pend) begin
                        for (int k = 0; k < INST_BYTES; k++)
                            if (cnt == 5'(k)) dbuf[8*k +: 8] <= mem_din;
                        cnt <= cnt + 5'd1;
                    end
                    pend <= (idx < len);
                end
                LS_WR: if (!io_stall) cnt <= cnt + 5'd1;
                default: ;
            endcase
        end else begin
            // A paused cycle's address never counts; the byte is reissued later.
            pend <= 1'b0;
        end
    end

    assign busy     = (state != IDLE);
    assign if_data  = dbuf;
    assign ls_rdata = dbuf[31:0];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-accurate bus traces against hand-derived values.
// Inputs change 1ns after the rising edge; outputs are checked 2ns after it.
module tb_mem_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, clr = 1'b0;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_wr = 1'b0, io_full = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic [1:0]  ls_len = '0;
    logic        if_done, ls_done, busy, mem_wr;
    logic [31:0] if_data, ls_rdata, mem_a;
    logic [7:0]  mem_din = '0, mem_dout;
    int          n_chk = 0, n_fail = 0;

    mem_arbiter #(.INST_BYTES(4), .IO_HI(2'b11)) dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .clear_in(clr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata), .busy(busy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_full)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram(input logic [31:0] a);
        case (a)
            32'h100: ram = 8'h13;
            32'h101: ram = 8'h05;
            32'h102: ram = 8'h00;
            32'h103: ram = 8'h00;
            32'h200: ram = 8'hAB;
            32'h800: ram = 8'hEF;
            32'h801: ram = 8'hBE;
            32'h802: ram = 8'hAD;
            32'h803: ram = 8'hDE;
            default: ram = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) mem_din <= ram(mem_a);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sw_b [4];
    logic       seen;

    initial begin
        sw_b[0] = 8'h78; sw_b[1] = 8'h56; sw_b[2] = 8'h34; sw_b[3] = 8'h12;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        chk("rst_done", {30'd0, if_done, ls_done}, 32'd0);
        rst_n = 1'b1;

        // 1: instruction fetch of 4 bytes
        step(); if_req = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 4; c++) begin
            step(); #1;
            chk($sformatf("if1_a%0d", c), mem_a, 32'h100 + 32'(c - 1));
            chk($sformatf("if1_wr%0d", c), 32'(mem_wr), 32'd0);
        end
        step(); #1; chk("if1_early", 32'(if_done), 32'd0);
        step(); #1; chk("if1_done", 32'(if_done), 32'd1);
        chk("if1_data", if_data, 32'h00000513);
        if_req = 1'b0;

        // 2: simultaneous requests, load byte wins
        step(); if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'b00; ls_addr = 32'h200;
        step(); #1; chk("lb2_a", mem_a, 32'h200);
        step();
        step(); #1; chk("lb2_done", 32'(ls_done), 32'd1);
        chk("lb2_data", ls_rdata, 32'h000000AB);
        chk("lb2_ifd", 32'(if_done), 32'd0);
        ls_req = 1'b0;
        step(); #1; chk("if2_idle", 32'(busy), 32'd0);
        step(); #1; chk("if2_a", mem_a, 32'h100);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step(); #1;
            if (if_done) seen = 1'b1;
        end
        chk("if2_done", 32'(seen), 32'd1);
        chk("if2_data", if_data, 32'h00000513);
        if_req = 1'b0;

        // 3: store word; io_full must not stall a RAM address
        step(); ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'b10;
        ls_addr = 32'h400; ls_wdata = 32'h12345678; io_full = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step(); #1;
            chk($sformatf("sw3_wr%0d", c), 32'(mem_wr), 32'd1);
            chk($sformatf("sw3_a%0d", c), mem_a, 32'h400 + 32'(c - 1));
            chk($sformatf("sw3_d%0d", c), 32'(mem_dout), 32'(sw_b[c - 1]));
        end
        step(); #1; chk("sw3_done", 32'(ls_done), 32'd1);
        chk("sw3_wr5", 32'(mem_wr), 32'd0);
        ls_req = 1'b0; io_full = 1'b0;

        // 4: store byte to IO while the UART buffer is full
        step(); ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'b00;
        ls_addr = 32'h30000; ls_wdata = 32'h41;
        for (int c = 1; c <= 3; c++) begin
            step(); io_full = 1'b1; #1;
            chk($sformatf("io4_hold%0d", c), 32'(mem_wr), 32'd0);
            chk($sformatf("io4_a%0d", c), mem_a, 32'h30000);
        end
        step(); io_full = 1'b0; #1;
        chk("io4_wr", 32'(mem_wr), 32'd1);
        chk("io4_d", 32'(mem_dout), 32'h41);
        step(); #1; chk("io4_done", 32'(ls_done), 32'd1);
        ls_req = 1'b0;

        // 5: flush during fetch, pending load taken next
        step(); if_req = 1'b1; if_addr = 32'h100;
        step(); #1; chk("clr5_a1", mem_a, 32'h100);
        step(); clr = 1'b1; if_req = 1'b0;
        ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'b00; ls_addr = 32'h200;
        step(); clr = 1'b0; #1;
        chk("clr5_a3", mem_a, 32'd0);
        chk("clr5_busy", 32'(busy), 32'd0);
        chk("clr5_ifd3", 32'(if_done), 32'd0);
        step(); #1; chk("clr5_lsa", mem_a, 32'h200);
        step(); #1; chk("clr5_ifd5", 32'(if_done), 32'd0);
        step(); #1; chk("clr5_done", 32'(ls_done), 32'd1);
        chk("clr5_data", ls_rdata, 32'h000000AB);
        ls_req = 1'b0;

        // 6: load word with a two-cycle pause
        step(); ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'b10; ls_addr = 32'h800;
        step(); #1; chk("rdy6_a1", mem_a, 32'h800);
        step(); rdy = 1'b0; #1; chk("rdy6_wr2", 32'(mem_wr), 32'd0);
        step(); #1; chk("rdy6_wr3", 32'(mem_wr), 32'd0);
        step(); rdy = 1'b1; #1; chk("rdy6_a4", mem_a, 32'h800);
        for (int c = 5; c <= 8; c++) begin
            step(); #1;
            chk($sformatf("rdy6_nd%0d", c), 32'(ls_done), 32'd0);
        end
        step(); #1; chk("rdy6_done", 32'(ls_done), 32'd1);
        chk("rdy6_data", ls_rdata, 32'hDEADBEEF);
        ls_req = 1'b0;

        // 7: halfword across the 32-bit address wrap
        step(); ls_req = 1'b1; ls_len = 2'b01; ls_addr = 32'hFFFFFFFF;
        step(); #1; chk("wrap7_a1", mem_a, 32'hFFFFFFFF);
        step();
        step();
        step(); #1; chk("wrap7_done", 32'(ls_done), 32'd1);
        chk("wrap7_data", ls_rdata, 32'h00005AA5);
        ls_req = 1'b0;

        // 8: asynchronous reset in the middle of a store
        step(); ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'b10;
        ls_addr = 32'h400; ls_wdata = 32'h12345678;
        step(); #1; chk("rst8_wr1", 32'(mem_wr), 32'd1);
        step(); #2; rst_n = 1'b0; #1;
        chk("rst8_wr", 32'(mem_wr), 32'd0);
        chk("rst8_a", mem_a, 32'd0);
        chk("rst8_d", 32'(mem_dout), 32'd0);
        chk("rst8_busy", 32'(busy), 32'd0);
        chk("rst8_data", ls_rdata, 32'd0);
        ls_req = 1'b0;
        step(); rst_n = 1'b1;
        step(); #1; chk("rst8_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
